// File: rtl/display_arbiter.sv
// ---------------------------------------------------------------------------
// display_arbiter
//
// Shares one display datapath between four requesters. The alarm requester
// (bit 3) always wins and can pre-empt a running grant. The other three
// (lev, status, hist) take turns in round-robin order. A non-alarm grant is
// held for at least HOLD_CYC cycles and at most TIMEOUT_CYC cycles. Every
// release is followed by one idle GAP cycle.
//
// Ports
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   sw       : system enable, 0 forces IDLE and drops any grant
//   req[3:0] : requests (3 alarm, 2 lev, 1 status, 0 hist)
//   done[3:0]: release indications, same bit mapping as req
//   gnt[3:0] : registered one-hot grant, zero when nothing is granted
//   sel[1:0] : registered index of the granted bit, holds when gnt is zero
//   busy     : registered, high whenever gnt is non-zero
//   preempt  : one-cycle pulse when an alarm forces a release
//   timeout  : one-cycle pulse when a non-alarm grant hits TIMEOUT_CYC
// ---------------------------------------------------------------------------
module display_arbiter #(
   parameter int HOLD_CYC    = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sw,
   input  logic [3:0] req,
   input  logic [3:0] done,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy,
   output logic       preempt,
   output logic       timeout
);

   typedef enum logic [1:0] {IDLE, ARB, GRANT, GAP} state_t;

   localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYC - 1);
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

   state_t     r_state;
   logic [7:0] r_holdCnt;
   logic [1:0] r_last;

   logic [1:0] w_rrIdx;
   logic [1:0] w_winIdx;
   logic       w_ownAlarm;
   logic       w_ownReq;
   logic       w_ownDone;
   logic       w_release;
   logic       w_preemptNow;
   logic       w_timeoutNow;

   // Round-robin pick among hist/status/lev. The search starts just after
   // the most recently granted non-alarm index and wraps around.
   always_comb begin
      w_rrIdx = 2'd0;
      case (r_last)
         2'd0: begin
            if (req[1])      w_rrIdx = 2'd1;
            else if (req[2]) w_rrIdx = 2'd2;
            else             w_rrIdx = 2'd0;
         end
         2'd1: begin
            if (req[2])      w_rrIdx = 2'd2;
            else if (req[0]) w_rrIdx = 2'd0;
            else             w_rrIdx = 2'd1;
         end
         default: begin
            if (req[0])      w_rrIdx = 2'd0;
            else if (req[1]) w_rrIdx = 2'd1;
            else             w_rrIdx = 2'd2;
         end
      endcase
   end

   assign w_winIdx   = req[3] ? 2'd3 : w_rrIdx;
   assign w_ownAlarm = (sel == 2'd3);
   assign w_ownReq   = req[sel];
   assign w_ownDone  = done[sel];

   // Release decision for the grant currently held. For a non-alarm owner,
   // an alarm request takes precedence, then a voluntary release once the
   // minimum hold is met, then the forced timeout. Alarm grants never time out.
   always_comb begin
      w_release    = 1'b0;
      w_preemptNow = 1'b0;
      w_timeoutNow = 1'b0;
      if (w_ownAlarm) begin
         w_release = done[3] | ~req[3];
      end else if (req[3]) begin
         w_release    = 1'b1;
         w_preemptNow = 1'b1;
      end else if ((r_holdCnt >= HOLD_LAST) && (w_ownDone || !w_ownReq)) begin
         w_release = 1'b1;
      end else if (r_holdCnt >= TIMEOUT_LAST) begin
         w_release    = 1'b1;
         w_timeoutNow = 1'b1;
      end
   end

   // Single state machine with all outputs registered. Pulses default low
   // every cycle and are raised only on the releasing edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_holdCnt <= 8'd0;
         r_last    <= 2'd2;
         gnt       <= 4'b0000;
         sel       <= 2'd0;
         busy      <= 1'b0;
         preempt   <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         preempt <= 1'b0;
         timeout <= 1'b0;
         if (!sw) begin
            r_state   <= IDLE;
            r_holdCnt <= 8'd0;
            gnt       <= 4'b0000;
            busy      <= 1'b0;
         end else begin
            case (r_state)
               IDLE: r_state <= ARB;
               ARB: begin
                  if (|req) begin
                     r_state   <= GRANT;
                     gnt       <= 4'b0001 << w_winIdx;
                     sel       <= w_winIdx;
                     busy      <= 1'b1;
                     r_holdCnt <= 8'd0;
                     if (!req[3]) r_last <= w_rrIdx;
                  end
               end
               GRANT: begin
                  if (w_release) begin
                     r_state <= GAP;
                     gnt     <= 4'b0000;
                     busy    <= 1'b0;
                     preempt <= w_preemptNow;
                     timeout <= w_timeoutNow;
                  end else if (r_holdCnt != 8'd255) begin
                     r_holdCnt <= r_holdCnt + 8'd1;
                  end
               end
               GAP:     r_state <= ARB;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_display_arbiter.sv
// ---------------------------------------------------------------------------
// tb_display_arbiter
//
// Drives display_arbiter with directed scenarios followed by random traffic.
// A behavioural model tracks who owns the display, how long they have held
// it, and whether the arbiter is enabled, waiting out a gap or ready to pick.
// Every cycle the five outputs are compared with the model's prediction.
// ---------------------------------------------------------------------------
module tb_display_arbiter;

   localparam int HOLD    = 8;
   localparam int TIMEOUT = 64;

   logic       clk;
   logic       rst;
   logic       sw;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;
   logic       preempt;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   // Model view of the arbiter
   int mOwner;        // -1 when nobody owns the display
   int mHeld;         // counter value seen during the current grant cycle
   int mLast;         // last non-alarm owner
   bit mReady;        // enabled and allowed to pick a winner this cycle
   bit mGap;          // in the mandatory idle cycle after a release
   int eSel;
   bit ePre;
   bit eTo;

   display_arbiter #(.HOLD_CYC(HOLD), .TIMEOUT_CYC(TIMEOUT)) dut (
      .clk     (clk),
      .rst     (rst),
      .sw      (sw),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .sel     (sel),
      .busy    (busy),
      .preempt (preempt),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expectation and count it
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed %0h expected %0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Predict the effect of one rising edge given the inputs now applied
   task automatic modelStep();
      bit released;
      ePre = 1'b0;
      eTo  = 1'b0;
      if (rst) begin
         mOwner = -1; mHeld = 0; mLast = 2; mReady = 0; mGap = 0; eSel = 0;
      end else if (!sw) begin
         mOwner = -1; mHeld = 0; mReady = 0; mGap = 0;
      end else if (mOwner >= 0) begin
         released = 1'b0;
         if (mOwner == 3) begin
            released = done[3] || !req[3];
         end else if (req[3]) begin
            released = 1'b1; ePre = 1'b1;
         end else if (mHeld >= HOLD - 1 && (done[mOwner] || !req[mOwner])) begin
            released = 1'b1;
         end else if (mHeld >= TIMEOUT - 1) begin
            released = 1'b1; eTo = 1'b1;
         end
         if (released) begin
            mOwner = -1; mGap = 1;
         end else if (mHeld < 255) begin
            mHeld++;
         end
      end else if (mGap) begin
         mGap = 0; mReady = 1;
      end else if (mReady) begin
         if (req != 4'b0000) begin
            if (req[3]) begin
               mOwner = 3;
            end else begin
               for (int k = 1; k <= 3; k++) begin
                  if (mOwner < 0 && req[(mLast + k) % 3]) mOwner = (mLast + k) % 3;
               end
               mLast = mOwner;
            end
            eSel = mOwner; mHeld = 0; mReady = 0;
         end
      end else begin
         mReady = 1;
      end
   endtask

   // Hold the given inputs for n cycles, checking outputs after every edge
   task automatic applyStimulus(input bit r, input bit s, input logic [3:0] rq,
                                input logic [3:0] dn, input int n);
      logic [3:0] eGnt;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = r; sw = s; req = rq; done = dn;
         modelStep();
         @(posedge clk);
         #1;
         eGnt = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'b0000;
         checkOutput("gnt",     32'(gnt),     32'(eGnt));
         checkOutput("sel",     32'(sel),     32'(eSel));
         checkOutput("busy",    32'(busy),    32'(mOwner >= 0));
         checkOutput("preempt", 32'(preempt), 32'(ePre));
         checkOutput("timeout", 32'(timeout), 32'(eTo));
      end
   endtask

   initial begin
      logic [3:0] rq;
      logic [3:0] dn;
      bit         r;
      bit         s;
      rst = 1'b1; sw = 1'b0; req = 4'b0000; done = 4'b0000;
      mOwner = -1; mHeld = 0; mLast = 2; mReady = 0; mGap = 0; eSel = 0;

      // Reset state, then round robin with a timeout on the first grant
      applyStimulus(1, 0, 4'b0000, 4'b0000, 3);
      applyStimulus(0, 1, 4'b0111, 4'b0000, 2);
      checkOutput("firstGnt", 32'(gnt), 32'h1);
      applyStimulus(0, 1, 4'b0111, 4'b0000, 63);
      applyStimulus(0, 1, 4'b0111, 4'b0000, 1);
      checkOutput("toPulse", 32'(timeout), 32'h1);
      applyStimulus(0, 1, 4'b0111, 4'b0000, 140);

      // Voluntary release waits for the minimum hold
      applyStimulus(1, 0, 4'b0000, 4'b0000, 1);
      applyStimulus(0, 1, 4'b0010, 4'b0000, 3);
      applyStimulus(0, 1, 4'b0010, 4'b0010, 12);

      // Alarm pre-empts hist at counter 3
      applyStimulus(1, 0, 4'b0000, 4'b0000, 1);
      applyStimulus(0, 1, 4'b0001, 4'b0000, 5);
      applyStimulus(0, 1, 4'b1001, 4'b0000, 1);
      checkOutput("prePulse", 32'(preempt), 32'h1);
      applyStimulus(0, 1, 4'b1001, 4'b0000, 4);
      applyStimulus(0, 1, 4'b0111, 4'b0000, 3);

      // Alarm held far beyond the timeout, then released by done
      applyStimulus(0, 1, 4'b1000, 4'b0000, 300);
      applyStimulus(0, 1, 4'b1000, 4'b1000, 1);
      checkOutput("alarmOff", 32'(gnt), 32'h0);
      applyStimulus(0, 1, 4'b0000, 4'b0000, 3);

      // Disable mid-grant, then resume with the stored pointer
      applyStimulus(0, 1, 4'b0110, 4'b0000, 4);
      applyStimulus(0, 0, 4'b0110, 4'b0000, 2);
      applyStimulus(0, 1, 4'b0110, 4'b0000, 4);

      // Reset mid-grant restores the initial search order
      applyStimulus(1, 1, 4'b0110, 4'b0000, 1);
      applyStimulus(0, 1, 4'b0111, 4'b0000, 3);
      checkOutput("postRst", 32'(gnt), 32'h1);

      // Random traffic with sticky requests so holds and timeouts occur
      rq = 4'b0000; dn = 4'b0000;
      for (int c = 0; c < 4000; c++) begin
         r = ($urandom_range(0, 299) == 0);
         s = ($urandom_range(0, 79) != 0);
         if ($urandom_range(0, 9) == 0) begin
            rq[2:0] = 3'($urandom);
            rq[3]   = ($urandom_range(0, 5) == 0);
         end
         dn = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
         applyStimulus(r, s, rq, dn, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter HOLD_CYC, 8, minimum grant duration in clk cycles before a non-alarm grant may be released (range 1..255).
REQ-002 Parameter TIMEOUT_CYC, 64, maximum grant duration in clk cycles for a non-alarm grant (range HOLD_CYC+1..255).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising clk edge.
REQ-005 sw  input  1  system enable; 0 forces IDLE and drops all grants.
REQ-006 req  input  4  display requests; bit3 alarm, bit2 lev, bit1 status, bit0 hist.
REQ-007 done  input  4  per-requester release indication, same bit mapping as req.
REQ-008 gnt  output  4  registered one-hot grant of the shared display datapath; all-zero when nothing is granted.
REQ-009 sel  output  2  registered binary index of the granted bit; holds its last value when gnt is 0.
REQ-010 busy  output  1  registered; 1 exactly when gnt is non-zero.
REQ-011 preempt  output  1  registered single-cycle pulse when an alarm request forces a release.
REQ-012 timeout  output  1  registered single-cycle pulse when a non-alarm grant is forcibly released at TIMEOUT_CYC.

Function
REQ-013 FSM states SHALL be IDLE, ARB, GRANT and GAP.
REQ-014 From any state, sw=0 SHALL force IDLE on the next edge, with gnt=0 and the hold counter cleared.
REQ-015 In IDLE, sw=1 SHALL go to ARB on the next edge.
REQ-016 In ARB with req=0, the FSM SHALL stay in ARB.
REQ-017 In ARB with any req bit set, the FSM SHALL go to GRANT: gnt, sel and busy update on that edge, and the hold counter loads 0.
- Latency: req sampled in ARB at cycle n -> gnt high in cycle n+1.
REQ-018 Arbitration: req[3] SHALL win unconditionally. Otherwise bits 2..0 are round-robin.
- Search order: (last+1)%3, (last+2)%3, (last+3)%3, where last is the most recently granted index among 0..2.
REQ-019 last SHALL update only when a non-alarm grant is issued; an alarm grant leaves it unchanged.
REQ-020 In GRANT, the hold counter SHALL increment by 1 per cycle and saturate at 255.
REQ-021 A non-alarm grant SHALL be released once the counter is >= HOLD_CYC-1 and either done[g]=1 or req[g]=0 (g = granted index).
- Before that point, done and req deassertion are ignored.
REQ-022 A non-alarm grant SHALL be released when the counter reaches TIMEOUT_CYC-1 even if req[g]=1 and done[g]=0; timeout pulses on the same edge the FSM enters GAP.
REQ-023 While a non-alarm grant is held, req[3]=1 SHALL cause a release on the next edge regardless of the hold counter; preempt pulses on that edge.
REQ-024 If preempt and timeout conditions coincide, only preempt SHALL pulse.
REQ-025 An alarm grant SHALL release only on done[3]=1 or req[3]=0, with no minimum hold and no timeout.
REQ-026 Every release SHALL enter GAP for exactly one cycle with gnt=0 and busy=0, then go to ARB.
- Any requester sees at least 2 cycles without a grant between grants.
REQ-027 gnt SHALL never have more than one bit set in any cycle.
REQ-028 done bits for non-granted requesters SHALL be ignored.
REQ-029 preempt and timeout SHALL be 0 in every cycle other than their defined pulse.

Reset
REQ-030 With rst=1 at an edge, the block SHALL set state=IDLE, gnt=0000, sel=00, busy=0, preempt=0, timeout=0, hold counter=0 and last=2.
- This applies in any state, including mid-grant, and takes priority over sw.
REQ-031 After reset, the first non-alarm arbitration SHALL search in order hist, status, lev.

Verification
REQ-032 Reset, sw=1, req=0111 held, done=0 -> gnt=0001 one cycle after entering ARB.
- Released by timeout after 64 grant cycles, with a timeout pulse.
- Then GAP, then gnt=0010, then 0100 (round-robin).
REQ-033 HOLD_CYC=8, req=0010 granted, done[1]=1 from grant cycle 2 -> grant held through counter=7, released on the next edge, no pulses.
REQ-034 req[0] granted at counter=3, req[3] asserted -> gnt=0000 and preempt=1 on the next edge.
- Then GAP, then gnt=1000; last remains 0.
REQ-035 Alarm granted 300 cycles with done=0 -> no timeout; done[3]=1 -> gnt=0000 next edge.
REQ-036 sw=0 during GRANT -> gnt=0000 and state IDLE next edge; sw=1 -> ARB, then grant per the stored last pointer.
REQ-037 rst=1 during GRANT with sw=1 -> all outputs zero on the next edge, last=2; next arbitration with req=0111 grants 0001.
